// File: rtl/axi_lite_arb.sv
// axi_lite_arb: round-robin arbiter sharing one AXI-Lite slave between NM masters, one transaction at a time.
// Optional transaction timeout with SLVERR response is enabled by defining AXI_LITE_ARB_TIMEOUT_EN.
module axi_lite_arb #(
    parameter int NM     = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TO_CYC = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NM-1:0]              s_awvalid,
    input  logic [NM-1:0]              s_wvalid,
    input  logic [NM-1:0]              s_arvalid,
    input  logic [NM-1:0]              s_bready,
    input  logic [NM-1:0]              s_rready,
    input  logic [NM*ADDR_W-1:0]       s_awaddr,
    input  logic [NM*ADDR_W-1:0]       s_araddr,
    input  logic [NM*3-1:0]            s_awprot,
    input  logic [NM*3-1:0]            s_arprot,
    input  logic [NM*DATA_W-1:0]       s_wdata,
    input  logic [NM*(DATA_W/8)-1:0]   s_wstrb,
    output logic [NM-1:0]              s_awready,
    output logic [NM-1:0]              s_wready,
    output logic [NM-1:0]              s_arready,
    output logic [NM-1:0]              s_bvalid,
    output logic [NM-1:0]              s_rvalid,
    output logic [1:0]                 s_bresp,
    output logic [1:0]                 s_rresp,
    output logic [DATA_W-1:0]          s_rdata,
    output logic                       m_awvalid,
    output logic                       m_wvalid,
    output logic                       m_arvalid,
    output logic [ADDR_W-1:0]          m_awaddr,
    output logic [ADDR_W-1:0]          m_araddr,
    output logic [2:0]                 m_awprot,
    output logic [2:0]                 m_arprot,
    output logic [DATA_W-1:0]          m_wdata,
    output logic [DATA_W/8-1:0]        m_wstrb,
    output logic                       m_bready,
    output logic                       m_rready,
    input  logic                       m_awready,
    input  logic                       m_wready,
    input  logic                       m_arready,
    input  logic                       m_bvalid,
    input  logic                       m_rvalid,
    input  logic [1:0]                 m_bresp,
    input  logic [1:0]                 m_rresp,
    input  logic [DATA_W-1:0]          m_rdata,
    output logic [$clog2(NM)-1:0]      grant,
    output logic                       busy
);

    localparam int GW = $clog2(NM);
    localparam int SW = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_B,
        RD_AR,
        RD_R
`ifdef AXI_LITE_ARB_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] rr, pick;
    logic          found, pick_wr;
    logic          aw_done, w_done;
    logic          aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic          aw_set, w_set;
    logic [NM-1:0] req;

    assign req   = s_awvalid | s_arvalid;
    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid & m_wready;
    assign ar_hs = m_arvalid & m_arready;
    assign b_hs  = m_bvalid & m_bready;
    assign r_hs  = m_rvalid & m_rready;
    assign busy  = (state != IDLE);

    // First requester at or after the round-robin pointer; a master's write beats its own read.
    always_comb begin
        found   = 1'b0;
        pick    = rr;
        pick_wr = 1'b0;
        for (int k = 0; k < NM; k++) begin
            if (!found && req[(int'(rr) + k) % NM]) begin
                found   = 1'b1;
                pick    = GW'((int'(rr) + k) % NM);
                pick_wr = s_awvalid[(int'(rr) + k) % NM];
            end
        end
    end

`ifdef AXI_LITE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC) + 1;

    logic [CW-1:0] cnt;
    logic          is_wr, ar_done, err_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            is_wr   <= 1'b0;
            ar_done <= 1'b0;
        end else if (state == IDLE) begin
            cnt     <= '0;
            ar_done <= 1'b0;
            if (found) is_wr <= pick_wr;
        end else begin
            cnt     <= cnt + 1'b1;
            ar_done <= ar_done | ar_hs | ((state == ERR) & ~is_wr & s_arvalid[grant]);
        end
    end

    assign err_hs = (state == ERR) &&
                    (is_wr ? (aw_done && w_done && s_bready[grant]) : (ar_done && s_rready[grant]));
    assign aw_set = aw_hs | ((state == ERR) & is_wr & ~aw_done & s_awvalid[grant]);
    assign w_set  = w_hs  | ((state == ERR) & is_wr & ~w_done & s_wvalid[grant]);
`else
    assign aw_set = aw_hs;
    assign w_set  = w_hs;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = pick_wr ? WR : RD_AR;
            WR:      if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = WR_B;
            WR_B:    if (b_hs) state_nxt = IDLE;
            RD_AR:   if (ar_hs) state_nxt = RD_R;
            RD_R:    if (r_hs) state_nxt = IDLE;
`ifdef AXI_LITE_ARB_TIMEOUT_EN
            ERR:     if (err_hs) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
`ifdef AXI_LITE_ARB_TIMEOUT_EN
        if (state != IDLE && state != ERR && cnt == CW'(TO_CYC - 1) && state_nxt != IDLE)
            state_nxt = ERR;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            rr      <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (found) grant <= pick;
            end else begin
                aw_done <= aw_done | aw_set;
                w_done  <= w_done | w_set;
                if (state_nxt == IDLE) rr <= GW'((int'(grant) + 1) % NM);
            end
        end
    end

    // Only the granted master's channels are connected, and only in the matching state.
    always_comb begin
        s_awready = '0;
        s_wready  = '0;
        s_arready = '0;
        s_bvalid  = '0;
        s_rvalid  = '0;
        s_bresp   = '0;
        s_rresp   = '0;
        s_rdata   = '0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_arvalid = 1'b0;
        m_bready  = 1'b0;
        m_rready  = 1'b0;
        m_awaddr  = '0;
        m_awprot  = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_araddr  = '0;
        m_arprot  = '0;
        case (state)
            WR: begin
                m_awaddr          = s_awaddr[int'(grant)*ADDR_W +: ADDR_W];
                m_awprot          = s_awprot[int'(grant)*3 +: 3];
                m_wdata           = s_wdata[int'(grant)*DATA_W +: DATA_W];
                m_wstrb           = s_wstrb[int'(grant)*SW +: SW];
                m_awvalid         = s_awvalid[grant] & ~aw_done;
                m_wvalid          = s_wvalid[grant] & ~w_done;
                s_awready[grant]  = m_awready & ~aw_done;
                s_wready[grant]   = m_wready & ~w_done;
            end
            WR_B: begin
                m_bready          = s_bready[grant];
                s_bvalid[grant]   = m_bvalid;
                if (m_bvalid) s_bresp = m_bresp;
            end
            RD_AR: begin
                m_araddr          = s_araddr[int'(grant)*ADDR_W +: ADDR_W];
                m_arprot          = s_arprot[int'(grant)*3 +: 3];
                m_arvalid         = s_arvalid[grant];
                s_arready[grant]  = m_arready;
            end
            RD_R: begin
                m_rready          = s_rready[grant];
                s_rvalid[grant]   = m_rvalid;
                if (m_rvalid) begin
                    s_rresp = m_rresp;
                    s_rdata = m_rdata;
                end
            end
`ifdef AXI_LITE_ARB_TIMEOUT_EN
            ERR: begin
                if (is_wr) begin
                    s_awready[grant] = ~aw_done;
                    s_wready[grant]  = ~w_done;
                    s_bvalid[grant]  = aw_done & w_done;
                    if (aw_done & w_done) s_bresp = 2'b10;
                end else begin
                    s_arready[grant] = ~ar_done;
                    s_rvalid[grant]  = ar_done;
                    if (ar_done) s_rresp = 2'b10;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule
